bsg_counter_max_clear_multi: RTL and testbench
==============================================

# bsg_counter_max_clear_multi

Multi-channel extreme-value tracker. Each of `els_p` channels holds the running maximum (or minimum) of the samples it has received since its last clear, plus a saturating sample count. A single-entry read-and-clear snapshot port drains one channel atomically. It sits beside performance monitors and credit/occupancy logic that need high- or low-watermarks over software-defined windows.

## Interface

**Parameters**
- `els_p`, no default (required): number of channels, ≥1.
- `width_p`, no default (required): sample and tracked-value width.
- `min_not_max_p`, default 0: 0 tracks the maximum, 1 tracks the minimum. Applies to all channels.
- `init_val_p`, default `'0`: value loaded on reset and on clear-without-sample. Use all-ones for min mode.
- `count_width_p`, default 8: width of the per-channel saturating sample counter.
- `id_width_lp`, default `BSG_SAFE_CLOG2(els_p)`: channel-select width.

**Ports**
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: reset. Asynchronous, active-low.
- `v_i`, in, `els_p`: per-channel sample valid.
- `data_i`, in, `els_p*width_p`: per-channel samples. Channel c is bits `[c*width_p +: width_p]`.
- `clear_i`, in, `els_p`: per-channel clear.
- `data_r_o`, out, `els_p*width_p`: tracked value per channel, registered.
- `count_r_o`, out, `els_p*count_width_p`: samples since the last clear, saturating, registered.
- `updated_r_o`, out, `els_p`: registered flag. 1 for a cycle when the previous cycle loaded a sample into the channel.
- `snap_v_i`, in, 1: snapshot request.
- `snap_id_i`, in, `id_width_lp`: channel to snapshot.
- `snap_ready_o`, out, 1: request can be accepted. Equals `~snap_v_o | snap_yumi_i`.
- `snap_v_o`, out, 1: snapshot output valid.
- `snap_data_o`, out, `width_p`: snapshot value.
- `snap_count_o`, out, `count_width_p`: snapshot count.
- `snap_yumi_i`, in, 1: consumer takes the snapshot. Legal only while `snap_v_o` is 1.

## Operation

**Acceptance and effective clear**
- A snapshot is accepted when `snap_v_i & snap_ready_o`.
- For channel c, the effective clear is `clr_c = clear_i[c] | (accept & snap_id_i == c)`.

**Per-channel update** (priority order):
- If `clr_c`:
  - value ← `v_i[c] ? data_i[c] : init_val_p`
  - count ← `v_i[c] ? 1 : 0`
- Else if `v_i[c]`:
  - count ← min(count+1, 2^count_width_p − 1)
  - value ← `data_i[c]` if it is strictly better, otherwise unchanged.
  - Better means `data_i[c] > value` when `min_not_max_p=0`, and `data_i[c] < value` when `min_not_max_p=1`.
  - All comparisons are unsigned.
- Else: hold.
- `updated_r_o[c]` ← 1 iff the value register was written from `data_i[c]` this cycle (clear with sample, or strictly better sample); otherwise 0. An equal sample does not set it.

**Snapshot**
- On accept, `snap_data_o` and `snap_count_o` capture the channel's registered value and count from before this cycle's update. A same-cycle sample therefore lands in the new window, not in the snapshot.
- `snap_v_o` ← 1 on accept.
- `snap_v_o` ← 0 on `snap_yumi_i` with no new accept in the same cycle.
- Accept and yumi in the same cycle replace the entry back-to-back (throughput 1/cycle).
- `snap_id_i ≥ els_p` is illegal and fires a simulation assertion. Hardware still accepts the request and returns `init_val_p` with count 0; no channel is cleared.
- `snap_yumi_i` while `snap_v_o=0`: assertion; ignored.

## Timing

- **Reset** (asynchronous, `reset_n_i=0`): all values = `init_val_p`, counts = 0, `updated_r_o` = 0, `snap_v_o` = 0, `snap_data_o` = 0, `snap_count_o` = 0. Takes effect immediately regardless of in-flight snapshots.
- Sample-to-output latency is 1 cycle for `data_r_o`, `count_r_o` and `updated_r_o`.
- Snapshot-request-to-`snap_v_o` latency is 1 cycle. The channel reads back cleared on the same edge.
- `snap_ready_o` is the only combinational output path (from `snap_yumi_i`). There is no path from `v_i`/`data_i` to any output.
- Counter saturation: at all-ones, further samples leave the count at all-ones; the value still updates.
- Per-channel logic is independent. Simultaneous activity on all channels plus a snapshot is fully supported in one cycle.

## Test plan

1. **Reset and basic max.** Max mode, `width_p=8`, `init_val_p=0`. Reset, then channel 0 samples 5, 3, 9 on consecutive cycles → `data_r_o[0]` = 5, 5, 9; count = 1, 2, 3; `updated_r_o[0]` = 1, 0, 1.
2. **Clear with sample.** Channel 1 holds 200. Assert `clear_i[1]` with `v_i[1]=1`, `data=4` → value 4, count 1. Assert `clear_i[1]` alone → value 0, count 0.
3. **Min mode.** `min_not_max_p=1`, `init_val_p=8'hFF`. Samples 50, 60, 10 → values 50, 50, 10. A sample equal to the held value leaves `updated_r_o` at 0 and increments the count.
4. **Snapshot with concurrent sample.** Channel 2 holds 77, count 3. Request `snap_id=2` while `v_i[2]=1`, `data=12` → next cycle `snap_v_o=1`, `snap_data_o=77`, `snap_count_o=3`; channel 2 value 12, count 1.
5. **Back-pressure.** With `snap_v_o=1` and `snap_yumi_i=0`, `snap_ready_o=0` and the request is not accepted (channel unchanged). Assert `snap_yumi_i` with `snap_v_i` → new snapshot is loaded the next cycle; `snap_v_o` stays 1.
6. **Saturation and async reset.** `count_width_p=2`: five samples → count 3. Drop `reset_n_i` mid-cycle while `snap_v_o=1` → all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/bsg_counter_max_clear_multi.sv
// ---------------------------------------------------------------------------
// bsg_counter_max_clear_multi
//
// Multi-channel extreme-value tracker. Each channel keeps the running maximum
// (or minimum when min_not_max_p=1) of the samples received since its last
// clear, plus a saturating sample count. A single-entry snapshot register
// drains one channel atomically: the channel's pre-update value/count are
// captured and the channel is cleared on the same edge.
//
// Ports
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   v_i            per-channel sample valid            [els_p]
//   data_i         per-channel samples                 [els_p*width_p]
//   clear_i        per-channel clear                   [els_p]
//   data_r_o       tracked value per channel (reg)     [els_p*width_p]
//   count_r_o      saturating sample count (reg)       [els_p*count_width_p]
//   updated_r_o    value was loaded from a sample      [els_p]
//   snap_v_i       snapshot request
//   snap_id_i      channel to snapshot                 [id_width_lp]
//   snap_ready_o   request can be accepted (~snap_v_o | snap_yumi_i)
//   snap_v_o       snapshot entry valid
//   snap_data_o    snapshot value                      [width_p]
//   snap_count_o   snapshot count                      [count_width_p]
//   snap_yumi_i    consumer takes the snapshot entry
// ---------------------------------------------------------------------------

// Protocol checks for the snapshot port; no hardware is generated from these.
//   clk_i, reset_n_i   clock / reset of the tracked block
//   snap_v_i           snapshot request
//   snap_id_i          requested channel
//   snap_v_q_i         current snapshot entry valid
//   snap_yumi_i        consumer take
module bsg_counter_max_clear_multi_chk #(
  parameter int els_p       = 1,
  parameter int id_width_lp = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   snap_v_i,
  input  logic [id_width_lp-1:0] snap_id_i,
  input  logic                   snap_v_q_i,
  input  logic                   snap_yumi_i
);

  // Sample the snapshot handshake on every active edge outside reset.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!snap_v_i || (32'(snap_id_i) < 32'(els_p)));
      assert (!snap_yumi_i || snap_v_q_i);
    end else begin
    end
  end

endmodule

module bsg_counter_max_clear_multi #(
  // els_p and width_p must be set by the instantiating module; the defaults
  // exist only so the module elaborates on its own.
  parameter int                 els_p         = 1,
  parameter int                 width_p       = 1,
  parameter bit                 min_not_max_p = 1'b0,
  parameter logic [width_p-1:0] init_val_p    = '0,
  parameter int                 count_width_p = 8,
  parameter int                 id_width_lp   = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [els_p-1:0]                 v_i,
  input  logic [els_p*width_p-1:0]         data_i,
  input  logic [els_p-1:0]                 clear_i,
  output logic [els_p*width_p-1:0]         data_r_o,
  output logic [els_p*count_width_p-1:0]   count_r_o,
  output logic [els_p-1:0]                 updated_r_o,
  input  logic                             snap_v_i,
  input  logic [id_width_lp-1:0]           snap_id_i,
  output logic                             snap_ready_o,
  output logic                             snap_v_o,
  output logic [width_p-1:0]               snap_data_o,
  output logic [count_width_p-1:0]         snap_count_o,
  input  logic                             snap_yumi_i
);

  logic [width_p-1:0]       val_q [els_p];
  logic [width_p-1:0]       val_d [els_p];
  logic [count_width_p-1:0] cnt_q [els_p];
  logic [count_width_p-1:0] cnt_d [els_p];
  logic [els_p-1:0]         upd_q;
  logic [els_p-1:0]         upd_d;

  logic                     snap_v_q;
  logic                     snap_v_d;
  logic [width_p-1:0]       snap_data_q;
  logic [width_p-1:0]       snap_data_d;
  logic [count_width_p-1:0] snap_count_q;
  logic [count_width_p-1:0] snap_count_d;

  logic                     accept_s;
  logic [els_p-1:0]         clr_s;
  logic [width_p-1:0]       sel_val_s;
  logic [count_width_p-1:0] sel_cnt_s;

  // The only combinational output: a taken entry frees the slot this cycle.
  assign snap_ready_o = ~snap_v_q | snap_yumi_i;
  assign accept_s     = snap_v_i & snap_ready_o;

  // Snapshot source mux; an out-of-range id matches no channel and so
  // reads back the init value with a zero count.
  always_comb begin
    sel_val_s = init_val_p;
    sel_cnt_s = '0;
    for (int c = 0; c < els_p; c++) begin
      sel_val_s = (snap_id_i == id_width_lp'(c)) ? val_q[c] : sel_val_s;
      sel_cnt_s = (snap_id_i == id_width_lp'(c)) ? cnt_q[c] : sel_cnt_s;
    end
  end

  // Per-channel next state: clear (explicit or by snapshot) beats sample.
  always_comb begin
    for (int c = 0; c < els_p; c++) begin
      clr_s[c] = clear_i[c] | (accept_s & (snap_id_i == id_width_lp'(c)));
      val_d[c] = val_q[c];
      cnt_d[c] = cnt_q[c];
      upd_d[c] = 1'b0;
      if (clr_s[c]) begin
        if (v_i[c]) begin
          val_d[c] = data_i[c*width_p +: width_p];
          cnt_d[c] = count_width_p'(1);
          upd_d[c] = 1'b1;
        end else begin
          val_d[c] = init_val_p;
          cnt_d[c] = '0;
        end
      end else if (v_i[c]) begin
        // Saturate at all-ones; the value still tracks.
        cnt_d[c] = (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + count_width_p'(1);
        // Strictly-better compare, unsigned; equal samples do not reload.
        if (min_not_max_p ? (data_i[c*width_p +: width_p] < val_q[c])
                          : (data_i[c*width_p +: width_p] > val_q[c])) begin
          val_d[c] = data_i[c*width_p +: width_p];
          upd_d[c] = 1'b1;
        end else begin
          val_d[c] = val_q[c];
        end
      end else begin
        val_d[c] = val_q[c];
      end
    end
  end

  // Snapshot entry next state: accept loads (also on a same-cycle take),
  // a take without a new accept empties the entry.
  always_comb begin
    snap_v_d     = snap_v_q;
    snap_data_d  = snap_data_q;
    snap_count_d = snap_count_q;
    if (accept_s) begin
      snap_v_d     = 1'b1;
      snap_data_d  = sel_val_s;
      snap_count_d = sel_cnt_s;
    end else if (snap_yumi_i) begin
      snap_v_d = 1'b0;
    end else begin
      snap_v_d = snap_v_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < els_p; c++) begin
        val_q[c] <= init_val_p;
        cnt_q[c] <= '0;
      end
      upd_q <= '0;
    end else begin
      for (int c = 0; c < els_p; c++) begin
        val_q[c] <= val_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      upd_q <= upd_d;
    end
  end

  // Snapshot entry registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      snap_v_q     <= 1'b0;
      snap_data_q  <= '0;
      snap_count_q <= '0;
    end else begin
      snap_v_q     <= snap_v_d;
      snap_data_q  <= snap_data_d;
      snap_count_q <= snap_count_d;
    end
  end

  for (genvar c = 0; c < els_p; c++) begin : gen_out
    assign data_r_o[c*width_p +: width_p]             = val_q[c];
    assign count_r_o[c*count_width_p +: count_width_p] = cnt_q[c];
  end

  assign updated_r_o  = upd_q;
  assign snap_v_o     = snap_v_q;
  assign snap_data_o  = snap_data_q;
  assign snap_count_o = snap_count_q;

  bsg_counter_max_clear_multi_chk #(
    .els_p       (els_p),
    .id_width_lp (id_width_lp)
  ) u_chk (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .snap_v_i    (snap_v_i),
    .snap_id_i   (snap_id_i),
    .snap_v_q_i  (snap_v_q),
    .snap_yumi_i (snap_yumi_i)
  );

endmodule

// File: tb/tb_bsg_counter_max_clear_multi.sv
// Directed bench for bsg_counter_max_clear_multi. Instance A: 4 channels of
// 8-bit max tracking with 2-bit counters. Instance B: 2 channels of 8-bit
// min tracking, init all-ones, 8-bit counters.
module tb_bsg_counter_max_clear_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [3:0]  a_v, a_clear, a_upd;
  logic [31:0] a_data, a_data_r;
  logic [7:0]  a_count_r;
  logic        a_snap_v, a_yumi, a_ready, a_snap_vo;
  logic [1:0]  a_snap_id, a_snap_count;
  logic [7:0]  a_snap_data;

  logic [1:0]  b_v, b_clear, b_upd;
  logic [15:0] b_data, b_data_r, b_count_r;
  logic        b_snap_v, b_yumi, b_ready, b_snap_vo;
  logic [0:0]  b_snap_id;
  logic [7:0]  b_snap_data, b_snap_count;

  int total = 0;
  int bad   = 0;

  bsg_counter_max_clear_multi #(
    .els_p(4), .width_p(8), .min_not_max_p(1'b0), .init_val_p(8'h00), .count_width_p(2)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(a_v), .data_i(a_data), .clear_i(a_clear),
    .data_r_o(a_data_r), .count_r_o(a_count_r), .updated_r_o(a_upd),
    .snap_v_i(a_snap_v), .snap_id_i(a_snap_id), .snap_ready_o(a_ready),
    .snap_v_o(a_snap_vo), .snap_data_o(a_snap_data), .snap_count_o(a_snap_count),
    .snap_yumi_i(a_yumi)
  );

  bsg_counter_max_clear_multi #(
    .els_p(2), .width_p(8), .min_not_max_p(1'b1), .init_val_p(8'hFF), .count_width_p(8)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(b_v), .data_i(b_data), .clear_i(b_clear),
    .data_r_o(b_data_r), .count_r_o(b_count_r), .updated_r_o(b_upd),
    .snap_v_i(b_snap_v), .snap_id_i(b_snap_id), .snap_ready_o(b_ready),
    .snap_v_o(b_snap_vo), .snap_data_o(b_snap_data), .snap_count_o(b_snap_count),
    .snap_yumi_i(b_yumi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] av(input int c);
    return 32'(a_data_r[c*8 +: 8]);
  endfunction
  function automatic logic [31:0] ac(input int c);
    return 32'(a_count_r[c*2 +: 2]);
  endfunction
  function automatic logic [31:0] bv(input int c);
    return 32'(b_data_r[c*8 +: 8]);
  endfunction
  function automatic logic [31:0] bc(input int c);
    return 32'(b_count_r[c*8 +: 8]);
  endfunction

  initial begin
    rst_n = 1'b1;
    a_v = 4'd0; a_clear = 4'd0; a_data = 32'd0; a_snap_v = 1'b0; a_snap_id = 2'd0; a_yumi = 1'b0;
    b_v = 2'd0; b_clear = 2'd0; b_data = 16'd0; b_snap_v = 1'b0; b_snap_id = 1'b0; b_yumi = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_data", a_data_r, 32'h0000_0000);
    chk("rst_a_count", 32'(a_count_r), 32'd0);
    chk("rst_a_upd", 32'(a_upd), 32'd0);
    chk("rst_a_snapv", 32'(a_snap_vo), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_data", 32'(b_data_r), 32'h0000_FFFF);
    chk("rst_b_count", 32'(b_count_r), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Basic max on channel 0: 5, 3, 9
    a_v = 4'b0001; a_data = 32'd5; tick();
    chk("t1_v0", av(0), 32'd5); chk("t1_c0", ac(0), 32'd1); chk("t1_u0", 32'(a_upd[0]), 32'd1);
    a_data = 32'd3; tick();
    chk("t1_v1", av(0), 32'd5); chk("t1_c1", ac(0), 32'd2); chk("t1_u1", 32'(a_upd[0]), 32'd0);
    a_data = 32'd9; tick();
    chk("t1_v2", av(0), 32'd9); chk("t1_c2", ac(0), 32'd3); chk("t1_u2", 32'(a_upd[0]), 32'd1);
    chk("t1_other", 32'(a_data_r[31:8]), 32'd0);
    a_v = 4'b0000; tick();
    chk("t1_hold_v", av(0), 32'd9); chk("t1_hold_u", 32'(a_upd[0]), 32'd0);

    // Saturation at 2 bits: equal sample, then a larger one
    a_v = 4'b0001; a_data = 32'd9; tick();
    chk("sat_c4", ac(0), 32'd3); chk("sat_u4", 32'(a_upd[0]), 32'd0);
    a_data = 32'd20; tick();
    chk("sat_c5", ac(0), 32'd3); chk("sat_v5", av(0), 32'd20); chk("sat_u5", 32'(a_upd[0]), 32'd1);
    a_v = 4'b0000;

    // Clear with and without sample on channel 1
    a_v = 4'b0010; a_data = {16'd0, 8'd200, 8'd0}; tick();
    chk("t2_load", av(1), 32'd200);
    a_clear = 4'b0010; a_data = {16'd0, 8'd4, 8'd0}; tick();
    chk("t2_clrs_v", av(1), 32'd4); chk("t2_clrs_c", ac(1), 32'd1); chk("t2_clrs_u", 32'(a_upd[1]), 32'd1);
    a_v = 4'b0000; tick();
    chk("t2_clr_v", av(1), 32'd0); chk("t2_clr_c", ac(1), 32'd0); chk("t2_clr_u", 32'(a_upd[1]), 32'd0);
    a_clear = 4'b0000;

    // Snapshot of channel 2 with a concurrent sample
    a_v = 4'b0100;
    a_data = {8'd0, 8'd77, 16'd0}; tick();
    a_data = {8'd0, 8'd10, 16'd0}; tick();
    a_data = {8'd0, 8'd30, 16'd0}; tick();
    chk("t4_pre_v", av(2), 32'd77); chk("t4_pre_c", ac(2), 32'd3);
    a_data = {8'd0, 8'd12, 16'd0}; a_snap_v = 1'b1; a_snap_id = 2'd2; #1;
    chk("t4_ready", 32'(a_ready), 32'd1);
    tick();
    chk("t4_snapv", 32'(a_snap_vo), 32'd1); chk("t4_sdata", 32'(a_snap_data), 32'd77);
    chk("t4_scnt", 32'(a_snap_count), 32'd3);
    chk("t4_v2", av(2), 32'd12); chk("t4_c2", ac(2), 32'd1); chk("t4_u2", 32'(a_upd[2]), 32'd1);
    a_v = 4'b0000;

    // Back-pressure: request for channel 0 while the entry is held
    a_snap_id = 2'd0; a_yumi = 1'b0; #1;
    chk("t5_notready", 32'(a_ready), 32'd0);
    tick();
    chk("t5_hold_sdata", 32'(a_snap_data), 32'd77); chk("t5_hold_v0", av(0), 32'd20);
    chk("t5_hold_c0", ac(0), 32'd3);
    a_yumi = 1'b1; #1;
    chk("t5_ready", 32'(a_ready), 32'd1);
    tick();
    chk("t5_snapv", 32'(a_snap_vo), 32'd1); chk("t5_sdata", 32'(a_snap_data), 32'd20);
    chk("t5_scnt", 32'(a_snap_count), 32'd3);
    chk("t5_v0", av(0), 32'd0); chk("t5_c0", ac(0), 32'd0); chk("t5_v2", av(2), 32'd12);
    a_snap_v = 1'b0; tick();
    chk("t5_drain", 32'(a_snap_vo), 32'd0);
    a_yumi = 1'b0;

    // Min mode on instance B: 50, 60, 10, 10
    b_v = 2'b01; b_data = {8'd0, 8'd50}; tick();
    chk("t3_v0", bv(0), 32'd50); chk("t3_u0", 32'(b_upd[0]), 32'd1); chk("t3_c0", bc(0), 32'd1);
    b_data = {8'd0, 8'd60}; tick();
    chk("t3_v1", bv(0), 32'd50); chk("t3_u1", 32'(b_upd[0]), 32'd0);
    b_data = {8'd0, 8'd10}; tick();
    chk("t3_v2", bv(0), 32'd10); chk("t3_u2", 32'(b_upd[0]), 32'd1); chk("t3_c2", bc(0), 32'd3);
    tick();
    chk("t3_eq_v", bv(0), 32'd10); chk("t3_eq_u", 32'(b_upd[0]), 32'd0); chk("t3_eq_c", bc(0), 32'd4);
    b_v = 2'b00; b_clear = 2'b01; tick();
    chk("t3_clr_v", bv(0), 32'hFF); chk("t3_clr_c", bc(0), 32'd0);
    b_clear = 2'b00;
    b_v = 2'b10; b_data = {8'd7, 8'd0}; tick();
    b_v = 2'b00; b_snap_v = 1'b1; b_snap_id = 1'b1; tick();
    chk("t3_snapv", 32'(b_snap_vo), 32'd1); chk("t3_sdata", 32'(b_snap_data), 32'd7);
    chk("t3_scnt", 32'(b_snap_count), 32'd1); chk("t3_v1clr", bv(1), 32'hFF);
    b_snap_v = 1'b0; b_yumi = 1'b1; tick();
    chk("t3_drain", 32'(b_snap_vo), 32'd0);
    b_yumi = 1'b0;

    // Asynchronous reset mid-cycle with a snapshot in flight
    a_v = 4'b1000; a_data = {8'd9, 24'd0}; tick();
    a_v = 4'b0000; a_snap_v = 1'b1; a_snap_id = 2'd3; tick();
    chk("t6_snapv", 32'(a_snap_vo), 32'd1); chk("t6_sdata", 32'(a_snap_data), 32'd9);
    chk("t6_scnt", 32'(a_snap_count), 32'd1);
    a_snap_v = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_snapv", 32'(a_snap_vo), 32'd0); chk("t6_rst_sdata", 32'(a_snap_data), 32'd0);
    chk("t6_rst_scnt", 32'(a_snap_count), 32'd0); chk("t6_rst_data", a_data_r, 32'd0);
    chk("t6_rst_cnt", 32'(a_count_r), 32'd0); chk("t6_rst_upd", 32'(a_upd), 32'd0);
    chk("t6_rst_ready", 32'(a_ready), 32'd1); chk("t6_rst_b", 32'(b_data_r), 32'h0000_FFFF);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
